// File: rtl/btn_event_unit_if.sv
// Signal bundle between raw board buttons, the conditioner and the CPU register block.
// slave is the conditioner's view; master is the board/CPU side.
interface btn_event_unit_if #(
  parameter int N_CH = 5
);
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] long_pulse;
  logic [N_CH-1:0] evt_press;
  logic [N_CH-1:0] evt_long;
  logic            clr_en;
  logic [N_CH-1:0] clr_mask;
  logic            irq;

  modport slave (
    input  btn_in, clr_en, clr_mask,
    output level, press_pulse, release_pulse, long_pulse, evt_press, evt_long, irq
  );

  modport master (
    output btn_in, clr_en, clr_mask,
    input  level, press_pulse, release_pulse, long_pulse, evt_press, evt_long, irq
  );
endinterface

// File: rtl/btn_event_unit.sv
// Multi-channel button conditioner: sync, debounce, press/release/long strobes, sticky events, irq.
// level flips DB_CYCLES+1 edges after a raw change; events one edge after strobes; irq one edge later.
module btn_event_unit #(
  parameter int          N_CH       = 5,
  parameter int          CNT_W      = 24,
  parameter int unsigned DB_CYCLES  = 100000,
  parameter int unsigned LP_CYCLES  = 10000000,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input logic              clk,
  input logic              rst,
  btn_event_unit_if.slave  bus
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(LP_CYCLES);
  localparam logic [N_CH-1:0]  RAW_RELEASED = ACTIVE_LOW ? '1 : '0;

  logic [N_CH-1:0]  s1, s2, pressed;
  logic [N_CH-1:0]  level_q, level_d;
  logic [N_CH-1:0]  press_q, press_d;
  logic [N_CH-1:0]  rel_q, rel_d;
  logic [N_CH-1:0]  long_q, long_d;
  logic [N_CH-1:0]  evtp_q, evtp_d;
  logic [N_CH-1:0]  evtl_q, evtl_d;
  logic [N_CH-1:0]  clr_vec;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] dcnt_q [N_CH];
  logic [CNT_W-1:0] dcnt_d [N_CH];
  logic [CNT_W-1:0] hcnt_q [N_CH];
  logic [CNT_W-1:0] hcnt_d [N_CH];

  assign pressed = ACTIVE_LOW ? ~s2 : s2;
  assign clr_vec = bus.clr_en ? bus.clr_mask : '0;

  always_comb begin
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    long_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      dcnt_d[i] = '0;
      hcnt_d[i] = '0;

      // Any cycle where the sampled input agrees with level restarts the stability window.
      if (pressed[i] != level_q[i]) begin
        if (dcnt_q[i] == DB_LAST) begin
          level_d[i] = pressed[i];
          press_d[i] = pressed[i];
          rel_d[i]   = ~pressed[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end

      // Saturating at LP_CYCLES guarantees a single long strobe per press.
      if (level_q[i]) begin
        if (hcnt_q[i] == LP_LAST) begin
          hcnt_d[i] = LP_MAX;
          long_d[i] = 1'b1;
        end else if (hcnt_q[i] == LP_MAX) begin
          hcnt_d[i] = hcnt_q[i];
        end else begin
          hcnt_d[i] = hcnt_q[i] + 1'b1;
        end
      end
    end

    // Set beats clear when both land on the same edge.
    evtp_d = (evtp_q & ~clr_vec) | press_q;
    evtl_d = (evtl_q & ~clr_vec) | long_q;
    irq_d  = |(evtp_q | evtl_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1      <= RAW_RELEASED;
      s2      <= RAW_RELEASED;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      evtp_q  <= '0;
      evtl_q  <= '0;
      irq_q   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        dcnt_q[i] <= '0;
        hcnt_q[i] <= '0;
      end
    end else begin
      s1      <= bus.btn_in;
      s2      <= s1;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      evtp_q  <= evtp_d;
      evtl_q  <= evtl_d;
      irq_q   <= irq_d;
      for (int i = 0; i < N_CH; i++) begin
        dcnt_q[i] <= dcnt_d[i];
        hcnt_q[i] <= hcnt_d[i];
      end
    end
  end

  assign bus.level         = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = rel_q;
  assign bus.long_pulse    = long_q;
  assign bus.evt_press     = evtp_q;
  assign bus.evt_long      = evtl_q;
  assign bus.irq           = irq_q;

endmodule

// File: tb/tb_btn_event_unit.sv
// Bench for btn_event_unit: directed vector table plus randomized traffic against a timestamp-based model.
module tb_btn_event_unit;
  localparam int N  = 2;
  localparam int DB = 4;
  localparam int LP = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  btn_event_unit_if #(.N_CH(N)) bus();

  btn_event_unit #(
    .N_CH(N), .CNT_W(8), .DB_CYCLES(DB), .LP_CYCLES(LP), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: edge-indexed timestamps instead of counters.
  int         t = 0;
  logic [1:0] hist[$];
  int         m_since[N];
  int         m_press_t[N];
  logic [1:0] m_lev, m_pp, m_rp, m_lp, m_ep, m_el;
  logic       m_irq;

  typedef struct {
    int         n;
    logic       r;
    logic [1:0] b;
    logic       ce;
    logic [1:0] cm;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(int n, logic r, logic [1:0] b, logic ce, logic [1:0] cm,
                             logic [1:0] lv, logic [1:0] pp, logic [1:0] rp, logic [1:0] lp,
                             logic [1:0] ep, logic [1:0] el, logic iq);
    vec_t x;
    x.n = n; x.r = r; x.b = b; x.ce = ce; x.cm = cm;
    x.exp = {lv, pp, rp, lp, ep, el, iq};
    return x;
  endfunction

  function automatic logic [12:0] obs();
    return {bus.level, bus.press_pulse, bus.release_pulse, bus.long_pulse,
            bus.evt_press, bus.evt_long, bus.irq};
  endfunction

  function automatic logic [12:0] model_vec();
    return {m_lev, m_pp, m_rp, m_lp, m_ep, m_el, m_irq};
  endfunction

  task automatic check(string nm, logic [12:0] act, logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got lvl/pp/rp/lp/ep/el/irq=%b want=%b", nm, t, act, exp);
    end
  endtask

  task automatic model_step();
    logic [1:0] p, nlev, npp, nrp, nlp, nep, nel, clr;
    logic nirq;
    t++;
    if (!rst) begin
      m_lev = '0; m_pp = '0; m_rp = '0; m_lp = '0; m_ep = '0; m_el = '0; m_irq = 1'b0;
      hist = '{2'b00, 2'b00};
      for (int i = 0; i < N; i++) begin
        m_since[i]   = t;
        m_press_t[i] = t;
      end
      return;
    end
    // The pressed value judged at this edge is the raw value from two edges ago.
    hist.push_front(bus.btn_in);
    p = hist[2];
    void'(hist.pop_back());
    nlev = m_lev; npp = '0; nrp = '0; nlp = '0;
    for (int i = 0; i < N; i++) begin
      if (m_lev[i] && (t - m_press_t[i] == LP)) nlp[i] = 1'b1;
      if (p[i] == m_lev[i]) begin
        m_since[i] = t;
      end else if (t - m_since[i] >= DB) begin
        nlev[i] = p[i];
        m_since[i] = t;
        if (p[i]) begin
          npp[i] = 1'b1;
          m_press_t[i] = t;
        end else begin
          nrp[i] = 1'b1;
        end
      end
    end
    clr  = bus.clr_en ? bus.clr_mask : 2'b00;
    nep  = (m_ep & ~clr) | m_pp;
    nel  = (m_el & ~clr) | m_lp;
    nirq = |(m_ep | m_el);
    m_lev = nlev; m_pp = npp; m_rp = nrp; m_lp = nlp; m_ep = nep; m_el = nel; m_irq = nirq;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model", obs(), model_vec());
  endtask

  initial begin
    bus.btn_in = '0; bus.clr_en = 1'b0; bus.clr_mask = '0;
    m_lev = '0; m_pp = '0; m_rp = '0; m_lp = '0; m_ep = '0; m_el = '0; m_irq = 1'b0;
    hist = '{2'b00, 2'b00};

    //               n  r  btn   ce  mask   lvl    pp     rp     lp     ep     el    irq
    tbl.push_back(v(3, 0, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0)); // in reset
    tbl.push_back(v(5, 1, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(v(1, 1, 2'b11, 0, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0)); // edge 5: press
    tbl.push_back(v(1, 1, 2'b11, 0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 0));
    tbl.push_back(v(1, 1, 2'b11, 0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 1));
    tbl.push_back(v(7, 1, 2'b11, 0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 1));
    tbl.push_back(v(1, 1, 2'b11, 0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 1)); // long
    tbl.push_back(v(1, 1, 2'b11, 0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 1));
    tbl.push_back(v(1, 1, 2'b11, 1, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 1)); // masked clear
    tbl.push_back(v(1, 1, 2'b11, 1, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1));
    tbl.push_back(v(1, 1, 2'b11, 0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(v(5, 1, 2'b00, 0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(v(1, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0)); // release
    tbl.push_back(v(1, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(v(3, 1, 2'b01, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0)); // glitch
    tbl.push_back(v(6, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(v(5, 1, 2'b01, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0)); // 5-cycle pulse
    tbl.push_back(v(1, 1, 2'b00, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(v(4, 1, 2'b00, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1));
    tbl.push_back(v(1, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 1));
    tbl.push_back(v(1, 1, 2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1));
    tbl.push_back(v(1, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(v(6, 1, 2'b10, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(v(1, 1, 2'b10, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 0)); // set beats clear
    tbl.push_back(v(1, 1, 2'b10, 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 1));
    tbl.push_back(v(4, 1, 2'b10, 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 1)); // hold count 6
    tbl.push_back(v(1, 0, 2'b10, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0)); // mid-hold reset
    tbl.push_back(v(5, 1, 2'b10, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(v(1, 1, 2'b10, 0, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(v(1, 1, 2'b10, 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 0));

    foreach (tbl[k]) begin
      rst          = tbl[k].r;
      bus.btn_in   = tbl[k].b;
      bus.clr_en   = tbl[k].ce;
      bus.clr_mask = tbl[k].cm;
      repeat (tbl[k].n) tick();
      check($sformatf("vec%0d", k), obs(), tbl[k].exp);
    end

    // Random segments long enough to cross both the debounce and long-press thresholds.
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      len = $urandom_range(1, 20);
      rst = ($urandom_range(0, 40) != 0);
      if (!rst) len = $urandom_range(1, 2);
      bus.btn_in = 2'($urandom_range(0, 3));
      for (int c = 0; c < len; c++) begin
        bus.clr_en   = ($urandom_range(0, 7) == 0);
        bus.clr_mask = 2'($urandom_range(0, 3));
        tick();
      end
    end

    rst = 1'b1;
    bus.clr_en = 1'b0;
    bus.btn_in = 2'b00;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/btn_event_unit.md
# btn_event_unit

Parametrised multi-channel push-button conditioner between raw board buttons and the CPU I/O space. For each channel it does the following:
- synchronises the raw input and debounces it;
- produces single-cycle press, release and long-press strobes;
- latches sticky press and long-press events that the CPU clears with a masked write.

One instance replaces per-button debounce instances in the top level and drives a single event interrupt line.

## Interface
Parameters:
- N_CH, 5: number of button channels.
- CNT_W, 24: width of the per-channel debounce and hold counters. Must hold both DB_CYCLES and LP_CYCLES.
- DB_CYCLES, 24'd100000: stable cycles required before the debounced level changes. Must be ≥ 1.
- LP_CYCLES, 24'd10000000: cycles the debounced level must stay high before a long press is reported. Must be ≥ 1.
- ACTIVE_LOW, 0: when 1, a raw input of 0 means pressed. Applied after synchronisation.

Ports:
- clk, input, 1: single system clock. All logic is on its rising edge.
- rst, input, 1: synchronous, active-low reset.
- btn_in, input, N_CH: raw asynchronous button inputs.
- level, output, N_CH: debounced pressed state, 1 = pressed.
- press_pulse, output, N_CH: one-cycle strobe when level rises.
- release_pulse, output, N_CH: one-cycle strobe when level falls.
- long_pulse, output, N_CH: one-cycle strobe once per press, when the hold time reaches LP_CYCLES.
- evt_press, output, N_CH: sticky press events.
- evt_long, output, N_CH: sticky long-press events.
- clr_en, input, 1: clear strobe from the CPU.
- clr_mask, input, N_CH: channels cleared when clr_en = 1.
- irq, output, 1: OR-reduction of evt_press | evt_long, registered.

## Operation
Each channel behaves identically and independently.
- **Synchroniser:** two flops s1 → s2. On reset both take the released raw value (ACTIVE_LOW ? 1 : 0). Polarity is applied to s2 to give the pressed bit p.
- **Debounce counter** `dcnt`:
  - If p == level: `dcnt` ← 0.
  - Otherwise, if `dcnt` == DB_CYCLES−1: level ← p, `dcnt` ← 0, and press_pulse or release_pulse ← 1 according to the new level.
  - Otherwise: `dcnt` ← `dcnt`+1.
  - A mismatch shorter than DB_CYCLES cycles produces no change.
- **Hold counter** `hcnt`:
  - Cleared while level == 0.
  - While level == 1 it increments, saturating at LP_CYCLES.
  - When level == 1 and `hcnt` == LP_CYCLES−1: `hcnt` ← LP_CYCLES and long_pulse ← 1.
  - It saturates, so there is at most one long_pulse per press.
- **Strobes:** press_pulse, release_pulse and long_pulse are registered, and are 0 on every cycle where their condition does not occur.
- **Sticky events:**
  - evt_press[i] is set on press_pulse[i]; evt_long[i] is set on long_pulse[i].
  - Both bits are cleared on the edge where clr_en && clr_mask[i].
  - If set and clear fall on the same edge, set wins and the bit stays 1.
  - A clear on an already-clear bit has no effect.
  - Unmasked channels are unaffected by the clear.
- **Interrupt:** irq is registered one cycle after the sticky bits.
- **Reset:**
  - While rst == 0, every output, counter and sticky bit is 0, including level.
  - Reset asserted mid-debounce or mid-hold discards the partial count. No strobe is emitted at reset entry or exit.
  - If a button is held through reset release, it is reported as a fresh press after DB_CYCLES+1 cycles.

## Timing
- **Debounce latency:** call the edge that first samples a new raw value into s1 edge 0. level flips at edge DB_CYCLES+1. press_pulse or release_pulse is high in the cycle following that edge, coincident with the first cycle of the new level.
- **Long-press latency:** long_pulse asserts exactly LP_CYCLES edges after the edge that asserts press_pulse, provided level stays 1 throughout.
- **Event latency:** evt_press and evt_long go high one edge after their strobe.
- **Interrupt latency:** irq goes high one further edge later. irq drops one edge after the last sticky bit clears.
- **Clear handshake:** clr_en is sampled on every edge and needs no acknowledge. The CPU may hold clr_en for several cycles.
- **Counter width:** all counter compares are at CNT_W bits. DB_CYCLES and LP_CYCLES values that do not fit in CNT_W are a configuration error, and the behaviour is not defined.

## Test plan
Bench configuration: N_CH=2, DB_CYCLES=4, LP_CYCLES=10, ACTIVE_LOW=0, CNT_W=8.
- **Reset:** hold rst=0 for 3 cycles with btn_in=2'b11, then release. All outputs are 0 during reset. After release, level[1:0] becomes 2'b11 at edge 5 after release, press_pulse=2'b11 for exactly one cycle, and evt_press=2'b11 one edge later.
- **Glitch rejection:** pulse btn_in[0]=1 for 3 cycles, then 0. level, press_pulse and evt_press stay 0. A 5-cycle pulse produces a press; the release follows 5 edges after the fall.
- **Long press:** hold btn_in[0]=1. long_pulse[0] asserts 10 edges after press_pulse[0], exactly once, and evt_long[0]=1. Release before 10 cycles: long_pulse stays 0, and release_pulse[0] fires.
- **Masked clear:** with evt_press=2'b11, drive clr_en=1 and clr_mask=2'b01 for one cycle. evt_press becomes 2'b10 and irq stays 1. A second clear with mask 2'b10 gives evt_press=0, and irq=0 one edge later.
- **Set-versus-clear collision:** assert clr_en with clr_mask[1]=1 in the same cycle as press_pulse[1]. evt_press[1] stays 1.
- **Mid-operation reset:** assert rst=0 for 1 cycle mid-hold, with hcnt=6. level drops to 0, no long_pulse or release_pulse is emitted, and a new press is reported 5 edges after release of reset if btn_in is still held.
